ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares one single_port_ram (64 x 8) between two requesters using round-robin arbitration.
- After reset, scrubs the whole RAM to zero before it accepts any traffic.
- Returns read data to the requester that issued the read, tagged by a per-port valid strobe.
- Sits between two client engines and the single_port_ram instance, which it owns.

Parameters:
- addr_width, 6, RAM address width.
- data_width, 8, RAM word width.
- depth, 64, number of RAM words; must equal 2**addr_width.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  synchronous active-low reset.
- req0  in  1  port 0 access request; held until granted.
- we0  in  1  port 0 write enable (1 = write, 0 = read); qualified by req0.
- addr0  in  addr_width  port 0 address.
- data0  in  data_width  port 0 write data.
- gnt0  out  1  port 0 grant; the access is taken on this cycle's rising edge.
- rvalid0  out  1  port 0 read data valid.
- req1, we1, addr1, data1, gnt1, rvalid1  same as port 0, for port 1.
- q  out  data_width  read data, shared by both ports and qualified by rvalid0/rvalid1.
- init_done  out  1  high once the scrub has finished.

Behaviour:
- Reset: while rst_n=0 at a clock edge, the block enters INIT with scrub counter 0 and round-robin pointer = port 0.
  - gnt0, gnt1, rvalid0, rvalid1 and init_done are all 0.
  - q follows the RAM output and is don't-care while no rvalid is high.
- Reset mid-operation: any in-flight read response is dropped (no rvalid), and the scrub restarts from address 0.
- FSM states: INIT, SERVE.
- INIT:
  - Drives we=1, data=0, addr=scrub counter to the RAM every cycle.
  - The counter increments each cycle.
  - After the write to address depth-1, the FSM moves to SERVE. The scrub takes exactly depth cycles.
  - gnt0 and gnt1 are forced to 0; requests stay pending.
- SERVE:
  - init_done=1 and stays 1 until the next reset.
  - Grants are combinational from the current req inputs and the priority pointer. At most one gnt is high per cycle.
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port the pointer favours is granted, and the pointer moves to the other port.
  - The pointer updates only on a cycle with a grant.
  - The RAM addr/we/data mux selects the granted port's signals.
  - Write latency: the RAM is written at the edge ending the grant cycle.
- Read latency:
  - A read granted in cycle N produces rvalid of the granted port = 1 for exactly cycle N+1, with q = RAM[addr].
  - The RAM registers the address and q is combinational from that register.
  - The response tag is a registered {valid, port} pair.
- Read-after-write: a read granted in cycle N+1 to an address written in cycle N returns the new data.
- Back-to-back: one access per cycle in total. Alternating grants under continuous contention give each port 50% of cycles.
- No request in SERVE: RAM we=0; rvalid stays 0 next cycle.
- Requesters must hold req/we/addr/data stable until gnt. Behaviour under mid-request changes is whatever the current-cycle values select.

Decomposition:
- Shared package: address/data width constants, FSM state encoding (INIT, SERVE), and port-index constants (PORT0=0, PORT1=1).
- Sub-module: one instance of the existing single_port_ram. The arbiter, mux, scrub counter and response tag stay in this module.

Test Plan:
- Reset then idle:
  - init_done rises exactly 64 cycles after rst_n goes high.
  - Reads from port 0 of addr 0, 31 and 63 return q=8'h00 with rvalid0 one cycle after gnt0.
- Port 0 alone:
  - Writes 8'h01, 8'h02, 8'h03 to addr 0, 1, 2 on consecutive cycles.
  - Reads of addr 0, 1, 2 then return 01, 02, 03 with rvalid0 only; rvalid1 stays 0.
- Contention:
  - req0 and req1 held high with reads to addr 5 (preloaded 8'hA5) and addr 6 (preloaded 8'h5A).
  - Grants alternate port 0, port 1, port 0, …
  - Each rvalid matches its own port, with q = A5 for port 0 and 5A for port 1.
- Read-after-write across ports: port 0 writes 8'h3C to addr 10, then port 1 reads addr 10 in the next cycle -> rvalid1 with q=8'h3C.
- Requests during INIT: req1 asserted at cycle 3 after reset -> gnt1 stays 0 until the first SERVE cycle, then is granted.
- Reset mid-operation:
  - rst_n pulled low on the cycle after a granted read -> no rvalid that cycle and init_done drops to 0.
  - After release, the scrub restarts and memory reads back 8'h00.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared constants and types for the two-port RAM arbiter
package ram_port_arbiter_pkg;

    localparam int ADDR_WIDTH = 6;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 64;

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/single_port_ram.sv
// rtl/single_port_ram.sv - single-port RAM with registered address and combinational read
module single_port_ram #(
    parameter int addr_width = 6,
    parameter int data_width = 8,
    parameter int depth      = 64
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] addr,
    input  logic [data_width-1:0] din,
    output logic [data_width-1:0] q
);

    logic [data_width-1:0] mem_q [depth];
    logic [addr_width-1:0] addr_d;
    logic [addr_width-1:0] addr_q;

    always_comb addr_d = addr;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        addr_q <= addr_d;
    end

    // Read through the registered address, so a write followed by a read returns new data.
    assign q = mem_q[addr_q];

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one scrubbed single-port RAM between two ports
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int addr_width = ADDR_WIDTH,
    parameter int data_width = DATA_WIDTH,
    parameter int depth      = DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [addr_width-1:0] addr0,
    input  logic [data_width-1:0] data0,
    output logic                  gnt0,
    output logic                  rvalid0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [addr_width-1:0] addr1,
    input  logic [data_width-1:0] data1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [data_width-1:0] q,
    output logic                  init_done
);

    state_t                state_q, state_d;
    logic [addr_width-1:0] scrub_q, scrub_d;
    logic                  ptr_q, ptr_d;
    logic                  init_done_q, init_done_d;
    logic                  rtag_valid_q, rtag_valid_d;
    logic                  rtag_port_q, rtag_port_d;

    logic                  gnt0_c, gnt1_c, gnt_any, gnt_port;
    logic                  ram_we;
    logic [addr_width-1:0] ram_addr;
    logic [data_width-1:0] ram_din;

    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (rst_n && state_q == SERVE) begin
            if (req0 && req1) begin
                gnt0_c = (ptr_q == PORT0);
                gnt1_c = (ptr_q == PORT1);
            end else begin
                gnt0_c = req0;
                gnt1_c = req1;
            end
        end
    end

    assign gnt_any  = gnt0_c | gnt1_c;
    assign gnt_port = gnt1_c ? PORT1 : PORT0;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = addr0;
        ram_din  = data0;
        if (state_q == INIT) begin
            ram_we   = 1'b1;
            ram_addr = scrub_q;
            ram_din  = '0;
        end else if (gnt_port == PORT1) begin
            ram_we   = gnt1_c & we1;
            ram_addr = addr1;
            ram_din  = data1;
        end else begin
            ram_we   = gnt0_c & we0;
        end
    end

    always_comb begin
        state_d      = state_q;
        scrub_d      = scrub_q;
        ptr_d        = ptr_q;
        init_done_d  = init_done_q;
        rtag_valid_d = gnt_any & ~ram_we;
        rtag_port_d  = gnt_port;
        case (state_q)
            INIT: begin
                scrub_d = scrub_q + 1'b1;
                if (scrub_q == addr_width'(depth - 1)) begin
                    state_d     = SERVE;
                    init_done_d = 1'b1;
                end
            end
            SERVE: begin
                // Favour the other port next time this one has been served.
                if (gnt_any) begin
                    ptr_d = ~gnt_port;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= INIT;
            scrub_q      <= '0;
            ptr_q        <= PORT0;
            init_done_q  <= 1'b0;
            rtag_valid_q <= 1'b0;
            rtag_port_q  <= PORT0;
        end else begin
            state_q      <= state_d;
            scrub_q      <= scrub_d;
            ptr_q        <= ptr_d;
            init_done_q  <= init_done_d;
            rtag_valid_q <= rtag_valid_d;
            rtag_port_q  <= rtag_port_d;
        end
    end

    single_port_ram #(
        .addr_width(addr_width),
        .data_width(data_width),
        .depth     (depth)
    ) u_ram (
        .clk (clk),
        .we  (ram_we),
        .addr(ram_addr),
        .din (ram_din),
        .q   (q)
    );

    assign gnt0      = gnt0_c;
    assign gnt1      = gnt1_c;
    // A response pending when reset arrives is dropped immediately.
    assign rvalid0   = rst_n & rtag_valid_q & (rtag_port_q == PORT0);
    assign rvalid1   = rst_n & rtag_valid_q & (rtag_port_q == PORT1);
    assign init_done = init_done_q;

endmodule
